// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: write scoreboard, youngest-producer operand
// bypass selection and load-use stall generation for the ID stage.
module hazard_ctrl #(
    parameter int DATA_W   = 16,
    parameter int NREG     = 16,
    parameter int DEPTH    = 3,
    parameter int ZERO_REG = 1,
    localparam int AW      = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic                    id_re0,
    input  logic                    id_re1,
    input  logic [AW-1:0]           id_src0,
    input  logic [AW-1:0]           id_src1,
    input  logic                    id_we,
    input  logic [AW-1:0]           id_dst,
    input  logic                    id_load,
    input  logic                    flush,
    input  logic [DATA_W-1:0]       rf_p0,
    input  logic [DATA_W-1:0]       rf_p1,
    input  logic [DEPTH*DATA_W-1:0] stage_data,
    output logic                    stall,
    output logic [DATA_W-1:0]       src0_ex,
    output logic [DATA_W-1:0]       src1_ex,
    output logic [2:0]              byp0_ex,
    output logic [2:0]              byp1_ex,
    output logic [15:0]             stall_cnt
);

    logic [DEPTH:1] sb_vld;
    logic [AW-1:0]  sb_dst [1:DEPTH];
    // Only the youngest entry's load flag matters: older loads can forward.
    logic           sb_load1;
    logic [15:0]    cnt_q;

    logic [DEPTH:1]    m0, m1;
    logic [2:0]        sel0_k, sel1_k;
    logic [DATA_W-1:0] sel0_d, sel1_d;
    logic              issue;
    logic              take;

    always_comb begin
        m0 = '0;
        m1 = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            m0[k] = id_re0 && sb_vld[k] && (sb_dst[k] == id_src0) &&
                    !((ZERO_REG != 0) && (id_src0 == '0));
            m1[k] = id_re1 && sb_vld[k] && (sb_dst[k] == id_src1) &&
                    !((ZERO_REG != 0) && (id_src1 == '0));
        end
    end

    // Scan oldest to youngest so the smallest matching stage is the final winner.
    always_comb begin
        sel0_k = '0;
        sel0_d = rf_p0;
        sel1_k = '0;
        sel1_d = rf_p1;
        for (int k = DEPTH; k >= 1; k--) begin
            if (m0[k]) begin
                sel0_k = 3'(k);
                sel0_d = stage_data[k*DATA_W-1 -: DATA_W];
            end
            if (m1[k]) begin
                sel1_k = 3'(k);
                sel1_d = stage_data[k*DATA_W-1 -: DATA_W];
            end
        end
    end

    assign stall = !rst && !flush && id_valid && sb_load1 && (m0[1] || m1[1]);
    assign issue = id_valid && id_we && !stall && !flush;
    assign take  = id_valid && !stall && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_vld   <= '0;
            sb_load1 <= 1'b0;
            src0_ex  <= '0;
            src1_ex  <= '0;
            byp0_ex  <= '0;
            byp1_ex  <= '0;
            cnt_q    <= '0;
        end else begin
            sb_vld   <= {sb_vld[DEPTH-1:1], issue};
            sb_load1 <= issue && id_load;
            src0_ex  <= take ? sel0_d : '0;
            src1_ex  <= take ? sel1_d : '0;
            byp0_ex  <= take ? sel0_k : '0;
            byp1_ex  <= take ? sel1_k : '0;
            if (stall && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        sb_dst[1] <= id_dst;
        for (int k = 2; k <= DEPTH; k++) begin
            sb_dst[k] <= sb_dst[k-1];
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, randomized run against an
// issue-history model, and counter saturation / reset-mid-stall sequences.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid, id_re0, id_re1, id_we, id_load, flush;
    logic [3:0]  id_src0, id_src1, id_dst;
    logic [15:0] rf_p0, rf_p1;
    logic [47:0] stage_data;
    logic        stall;
    logic [15:0] src0_ex, src1_ex, stall_cnt;
    logic [2:0]  byp0_ex, byp1_ex;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_re0(id_re0), .id_re1(id_re1),
        .id_src0(id_src0), .id_src1(id_src1), .id_we(id_we), .id_dst(id_dst),
        .id_load(id_load), .flush(flush), .rf_p0(rf_p0), .rf_p1(rf_p1),
        .stage_data(stage_data), .stall(stall), .src0_ex(src0_ex), .src1_ex(src1_ex),
        .byp0_ex(byp0_ex), .byp1_ex(byp1_ex), .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        valid, re0, re1;
        logic [3:0]  src0, src1;
        logic        we;
        logic [3:0]  dst;
        logic        load, flush;
        logic [15:0] rf0, rf1;
        logic [47:0] sd;
        logic        e_stall;
        logic [2:0]  e_byp0;
        logic [15:0] e_src0;
        logic [2:0]  e_byp1;
        logic [15:0] e_src1;
        logic [15:0] e_cnt;
    } vec_t;

    typedef struct {
        logic       vld;
        logic [3:0] dst;
        logic       load;
    } ent_t;

    vec_t vecs [14];
    ent_t hist [$];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic r0, input logic r1, input logic [3:0] s0,
                         input logic [3:0] s1, input logic w, input logic [3:0] d,
                         input logic ld, input logic fl, input logic [15:0] p0,
                         input logic [15:0] p1, input logic [47:0] sd);
        id_valid = v; id_re0 = r0; id_re1 = r1; id_src0 = s0; id_src1 = s1;
        id_we = w; id_dst = d; id_load = ld; flush = fl; rf_p0 = p0; rf_p1 = p1;
        stage_data = sd;
    endtask

    // Reference: history of issued writes, newest first; the first hit is the youngest producer.
    function automatic void model_sel(input logic re, input logic [3:0] s, input logic [15:0] rf,
                                      input logic [47:0] sd, output logic [2:0] b,
                                      output logic [15:0] d);
        b = 3'd0;
        d = rf;
        if (re && s != 4'd0) begin
            for (int i = 0; i < hist.size(); i++) begin
                if (hist[i].vld && hist[i].dst == s) begin
                    b = 3'(i + 1);
                    d = sd[i*16 +: 16];
                    break;
                end
            end
        end
    endfunction

    function automatic logic model_stall();
        logic hit;
        hit = hist[0].vld && hist[0].load &&
              ((id_re0 && id_src0 != 4'd0 && hist[0].dst == id_src0) ||
               (id_re1 && id_src1 != 4'd0 && hist[0].dst == id_src1));
        return !rst && !flush && id_valid && hit;
    endfunction

    task automatic clear_hist();
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back('{1'b0, 4'd0, 1'b0});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 48'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0]  eb0, eb1;
        logic [15:0] ed0, ed1, ecnt;
        logic        es;

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 48'h0);
        vecs[0]  = '{1,1,1,4'd1,4'd2,1,4'd3,0,0,16'hAAAA,16'hBBBB,48'h0,               0,3'd0,16'hAAAA,3'd0,16'hBBBB,16'd0};
        vecs[1]  = '{1,1,1,4'd3,4'd2,1,4'd6,0,0,16'hAAAA,16'hBBBB,48'h3333_2222_1234,  0,3'd1,16'h1234,3'd0,16'hBBBB,16'd0};
        vecs[2]  = '{1,1,0,4'd7,4'd0,1,4'd5,1,0,16'h0101,16'h0000,48'h0,               0,3'd0,16'h0101,3'd0,16'h0000,16'd0};
        vecs[3]  = '{1,1,0,4'd5,4'd0,1,4'd8,0,0,16'h0000,16'h0000,48'h0,               1,3'd0,16'h0000,3'd0,16'h0000,16'd1};
        vecs[4]  = '{1,1,0,4'd5,4'd0,1,4'd8,0,0,16'h0000,16'h0000,48'h3333_5555_1111,  0,3'd2,16'h5555,3'd0,16'h0000,16'd1};
        vecs[5]  = '{1,0,0,4'd0,4'd0,1,4'd4,0,0,16'h0000,16'h0000,48'h0,               0,3'd0,16'h0000,3'd0,16'h0000,16'd1};
        vecs[6]  = '{0,0,0,4'd0,4'd0,0,4'd0,0,0,16'h0000,16'h0000,48'h0,               0,3'd0,16'h0000,3'd0,16'h0000,16'd1};
        vecs[7]  = '{1,0,0,4'd0,4'd0,1,4'd4,0,0,16'h0000,16'h0000,48'h0,               0,3'd0,16'h0000,3'd0,16'h0000,16'd1};
        vecs[8]  = '{1,1,1,4'd4,4'd4,0,4'd0,0,0,16'h0000,16'h0000,48'hCCCC_DDDD_EEEE,  0,3'd1,16'hEEEE,3'd1,16'hEEEE,16'd1};
        vecs[9]  = '{1,0,0,4'd0,4'd0,1,4'd0,1,0,16'h0000,16'h0000,48'h0,               0,3'd0,16'h0000,3'd0,16'h0000,16'd1};
        vecs[10] = '{1,1,0,4'd0,4'd0,0,4'd0,0,0,16'h0F0F,16'h0000,48'h0,               0,3'd0,16'h0F0F,3'd0,16'h0000,16'd1};
        vecs[11] = '{1,0,0,4'd0,4'd0,1,4'd9,1,0,16'h0000,16'h0000,48'h0,               0,3'd0,16'h0000,3'd0,16'h0000,16'd1};
        vecs[12] = '{1,1,1,4'd9,4'd9,0,4'd0,0,1,16'h1111,16'h2222,48'h0,               0,3'd0,16'h0000,3'd0,16'h0000,16'd1};
        vecs[13] = '{1,1,1,4'd9,4'd9,0,4'd0,0,0,16'h0000,16'h0000,48'h7777_9999_AAAA,  0,3'd2,16'h9999,3'd2,16'h9999,16'd1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", stall, 0);
        chk("reset_byp0", byp0_ex, 0);
        chk("reset_byp1", byp1_ex, 0);
        chk("reset_src0", src0_ex, 0);
        chk("reset_cnt", stall_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table
        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].re0, vecs[i].re1, vecs[i].src0, vecs[i].src1,
                  vecs[i].we, vecs[i].dst, vecs[i].load, vecs[i].flush,
                  vecs[i].rf0, vecs[i].rf1, vecs[i].sd);
            #1;
            chk($sformatf("vec%0d_stall", i), stall, vecs[i].e_stall);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_byp0", i), byp0_ex, vecs[i].e_byp0);
            chk($sformatf("vec%0d_src0", i), src0_ex, vecs[i].e_src0);
            chk($sformatf("vec%0d_byp1", i), byp1_ex, vecs[i].e_byp1);
            chk($sformatf("vec%0d_src1", i), src1_ex, vecs[i].e_src1);
            chk($sformatf("vec%0d_cnt", i), stall_cnt, vecs[i].e_cnt);
            @(negedge clk);
        end

        // Randomized run against the history model
        clear_hist();
        ecnt = 16'd0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            rst = (n == 0) || ($urandom_range(0, 49) == 0);
            drive(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom),
                  4'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 11) == 0), 16'($urandom), 16'($urandom),
                  {16'($urandom), 16'($urandom), 16'($urandom)});
            #1;
            es = model_stall();
            chk($sformatf("rnd%0d_stall", n), stall, es);
            model_sel(id_re0, id_src0, rf_p0, stage_data, eb0, ed0);
            model_sel(id_re1, id_src1, rf_p1, stage_data, eb1, ed1);
            if (rst || es || flush || !id_valid) begin
                eb0 = 0; ed0 = 0; eb1 = 0; ed1 = 0;
            end
            if (rst) begin
                ecnt = 0;
                clear_hist();
            end else begin
                if (es && ecnt != 16'hFFFF) ecnt = ecnt + 1;
                hist.push_front('{id_valid && id_we && !es && !flush, id_dst, id_load});
                void'(hist.pop_back());
            end
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d_byp0", n), byp0_ex, eb0);
            chk($sformatf("rnd%0d_src0", n), src0_ex, ed0);
            chk($sformatf("rnd%0d_byp1", n), byp1_ex, eb1);
            chk($sformatf("rnd%0d_src1", n), src1_ex, ed1);
            chk($sformatf("rnd%0d_cnt", n), stall_cnt, ecnt);
        end

        // Saturation: preload counter near the top, then alternate load-use stalls
        do_reset();
        @(negedge clk);
        force dut.cnt_q = 16'hFFF0;
        @(negedge clk);
        release dut.cnt_q;
        for (int i = 0; i <= 40; i++) begin
            drive(1, 1, 0, 4'd1, 4'd0, 1, 4'd1, 1, 0, 16'h4242, 16'h0, 48'h0);
            #1;
            chk($sformatf("sat%0d_stall", i), stall, (i % 2 == 1));
            @(negedge clk);
        end
        chk("sat_cnt", stall_cnt, 16'hFFFF);

        // Reset while a load-use hazard is pending
        rst = 1'b1;
        #1;
        chk("rst_mid_stall", stall, 0);
        @(posedge clk);
        #1;
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_byp0", byp0_ex, 0);
        chk("rst_byp1", byp1_ex, 0);
        chk("rst_src0", src0_ex, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_stall", stall, 0);
        @(posedge clk);
        #1;
        chk("post_rst_byp0", byp0_ex, 0);
        chk("post_rst_src0", src0_ex, 16'h4242);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, width of operand/result data.
REQ-002 Parameter NREG, default 16, register count; AW = clog2(NREG) address width.
REQ-003 Parameter DEPTH, default 3, in-flight write stages after ID (1 = EX ... DEPTH = WB), range 2..6.
REQ-004 Parameter ZERO_REG, default 1, when 1 register 0 never creates a hazard or bypass.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 id_valid  in  1  ID holds a real instruction.
REQ-008 id_re0 / id_re1  in  1 each  ID reads port 0 / port 1.
REQ-009 id_src0 / id_src1  in  AW each  ID source register addresses.
REQ-010 id_we  in  1  ID instruction writes a register.
REQ-011 id_dst  in  AW  ID destination address.
REQ-012 id_load  in  1  ID instruction is a memory load.
REQ-013 flush  in  1  taken branch/jump; instruction in ID is wrong-path.
REQ-014 rf_p0 / rf_p1  in  DATA_W each  register file read data for the ID sources.
REQ-015 stage_data  in  DEPTH*DATA_W  result of stage k at bits [k*DATA_W-1:(k-1)*DATA_W].
REQ-016 stall  out  1  combinational; holds PC and IF/ID latch.
REQ-017 src0_ex / src1_ex  out  DATA_W each  registered forwarded operands for EX.
REQ-018 byp0_ex / byp1_ex  out  3 each  registered source stage of each operand (0 = RF, k = stage k).
REQ-019 stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-020 Scoreboard of DEPTH entries {vld, dst, load}; every cycle entry[k+1] <= entry[k], entry[DEPTH] retires.
REQ-021 entry[1] <= {1, id_dst, id_load} when id_valid & id_we & ~stall & ~flush; otherwise bubble (vld=0).
REQ-022 Entry matches source s when vld & dst==s & re for that port & ~(ZERO_REG & s==0).
REQ-023 Bypass selection: smallest matching k wins (youngest producer); no match selects RF.
REQ-024 Load-use: stall=1 when entry[1] matches either active source with load=1 and id_valid=1; load data usable from stage 2 onward.
REQ-025 Load matched at stage >= 2 forwards normally, no stall.
REQ-026 flush=1 forces stall=0 and inserts a bubble, regardless of hazard.
REQ-027 src*_ex/byp*_ex update with selected data/stage when ~stall & ~flush & id_valid; on stall or flush they load 0/0 (bubble to EX).
REQ-028 Operand data is sampled from rf_p*/stage_data in the same cycle as selection; one-cycle latency ID -> EX outputs.
REQ-029 Both ports evaluated independently; same source on both ports yields identical selection.
REQ-030 stall_cnt increments each cycle stall=1; holds at 16'hFFFF.
REQ-031 Stall is combinational from current inputs and scoreboard only; no combinational path from flush to scoreboard other than REQ-021.

Reset
REQ-032 On rst=1 at clock edge: all entry vld=0, src*_ex=0, byp*_ex=0, stall_cnt=0.
REQ-033 During rst stall=0; reset mid-stall abandons the stall and clears the scoreboard on the same edge.
REQ-034 First instruction after rst release sees no hazards (all sources from RF).

Verification (DEPTH=3, DATA_W=16)
REQ-035 ADD R3 then ADD using R3 on port 0 next cycle, stage_data[1]=16'h1234 -> byp0_ex=1, src0_ex=16'h1234, stall=0.
REQ-036 LW R5 then instruction reading R5 -> stall=1 for exactly one cycle, then byp=2 with load data; stall_cnt=1.
REQ-037 R4 written at stages 1 and 3 simultaneously -> byp=1 (youngest), stage-1 data used.
REQ-038 Source R0 with ZERO_REG=1 and entry[1].dst=0 -> byp=0, src=rf_p0, no stall.
REQ-039 Load-use hazard with flush=1 same cycle -> stall=0, src*_ex=0, entry[1] bubble.
REQ-040 Force 65540 consecutive stall cycles -> stall_cnt=16'hFFFF; assert rst -> stall_cnt=0, all byp=0 next cycle.
